// File: rtl/snake_dir_ctrl.sv
// Snake direction/game-flow controller: merges key and IR events into a filtered
// turn queue, applies one turn per game step. Optional SNAKE_TURN_BEEP_EN adds turn_beep.
module snake_dir_ctrl #(
    parameter int         QDEPTH   = 4,
    parameter logic [7:0] IR_UP    = 8'h18,
    parameter logic [7:0] IR_DOWN  = 8'h52,
    parameter logic [7:0] IR_LEFT  = 8'h08,
    parameter logic [7:0] IR_RIGHT = 8'h5A,
    parameter logic [7:0] IR_PAUSE = 8'h1C
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] key_flag,
    input  logic [3:0] key_value,
    input  logic       ir_data_en,
    input  logic [7:0] ir_data,
    input  logic       step_tick,
    input  logic       game_over,
    output logic [1:0] dir_out,
    output logic       dir_valid,
    output logic       run,
    output logic       paused,
    output logic       restart,
    output logic [3:0] q_cnt,
    output logic       drop,
    output logic       turn_beep
);

    localparam int         AW    = $clog2(QDEPTH);
    localparam logic [3:0] QFULL = 4'(QDEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVER} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_dir;
    logic            r_dir_valid, r_run, r_paused, r_restart, r_drop;
    logic [1:0]      r_q [QDEPTH];
    logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [3:0]      r_cnt;

    logic [3:0]      w_key_ev;
    logic            w_ir_hit, w_ir_pause, w_dir_any, w_multi;
    logic [1:0]      w_ir_dir, w_dir_sel, w_ref, w_head;
    logic [AW-1:0]   w_tail_idx;
    logic            w_full, w_filt_rej;
    logic            w_push, w_pop, w_flush, w_step, w_set_dir, w_drop, w_restart;

    // Key bit order is {up,down,left,right}; a key counts only on a press edge.
    assign w_key_ev   = key_flag & ~key_value;
    assign w_ir_pause = ir_data_en && (ir_data == IR_PAUSE);

    always_comb begin
        w_ir_hit = 1'b0;
        w_ir_dir = 2'b00;
        if (ir_data_en) begin
            if (ir_data == IR_UP) begin
                w_ir_hit = 1'b1; w_ir_dir = 2'b00;
            end else if (ir_data == IR_DOWN) begin
                w_ir_hit = 1'b1; w_ir_dir = 2'b01;
            end else if (ir_data == IR_LEFT) begin
                w_ir_hit = 1'b1; w_ir_dir = 2'b10;
            end else if (ir_data == IR_RIGHT) begin
                w_ir_hit = 1'b1; w_ir_dir = 2'b11;
            end
        end
    end

    always_comb begin
        w_dir_sel = w_ir_dir;
        if      (w_key_ev[3]) w_dir_sel = 2'b00;
        else if (w_key_ev[2]) w_dir_sel = 2'b01;
        else if (w_key_ev[1]) w_dir_sel = 2'b10;
        else if (w_key_ev[0]) w_dir_sel = 2'b11;
    end

    assign w_dir_any = (|w_key_ev) || w_ir_hit;
    // More than one direction source active: more than one key bit, or a key plus IR.
    assign w_multi   = ((w_key_ev & (w_key_ev - 4'd1)) != 4'd0) || ((|w_key_ev) && w_ir_hit);

    // Filter against the pre-pop tail so a same-cycle pop never changes the decision.
    assign w_tail_idx = r_wr_ptr - AW'(1);
    assign w_head     = r_q[r_rd_ptr];
    assign w_ref      = (r_cnt != 4'd0) ? r_q[w_tail_idx] : r_dir;
    assign w_full     = (r_cnt == QFULL);
    assign w_filt_rej = (w_dir_sel == w_ref) || (w_dir_sel == (w_ref ^ 2'b01));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_step      = 1'b0;
        w_set_dir   = 1'b0;
        w_drop      = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dir_any) begin
                    w_set_dir   = 1'b1;
                    w_drop      = w_multi;
                    w_state_nxt = S_RUN;
                end else if (w_ir_pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (game_over) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_OVER;
                end else begin
                    w_step = step_tick;
                    w_pop  = step_tick && (r_cnt != 4'd0);
                    if (w_dir_any) begin
                        if (w_filt_rej || w_full) begin
                            w_drop = 1'b1;
                        end else begin
                            w_push = 1'b1;
                            w_drop = w_multi;
                        end
                    end
                    if (w_ir_pause) w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (game_over) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_OVER;
                end else if (w_ir_pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_OVER: begin
                if (w_ir_pause || (|w_key_ev)) begin
                    w_flush     = 1'b1;
                    w_restart   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_dir       <= 2'b11;
            r_dir_valid <= 1'b0;
            r_run       <= 1'b0;
            r_paused    <= 1'b0;
            r_restart   <= 1'b0;
            r_drop      <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= 4'd0;
            for (int i = 0; i < QDEPTH; i++) r_q[i] <= 2'b00;
        end else begin
            r_dir_valid <= w_step;
            r_drop      <= w_drop;
            r_restart   <= w_restart;
            r_run       <= (w_state_nxt == S_RUN);
            r_paused    <= (w_state_nxt == S_PAUSE);

            if (w_restart)      r_dir <= 2'b11;
            else if (w_set_dir) r_dir <= w_dir_sel;
            else if (w_pop)     r_dir <= w_head;

            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= 4'd0;
            end else begin
                if (w_push) begin
                    r_q[r_wr_ptr] <= w_dir_sel;
                    r_wr_ptr      <= r_wr_ptr + AW'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 4'd1;
                    2'b01:   r_cnt <= r_cnt - 4'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

`ifdef SNAKE_TURN_BEEP_EN
    logic r_beep;
    // Only a pop can change the heading on a step; an empty-queue step never beeps.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_beep <= 1'b0;
        else         r_beep <= w_pop && (w_head != r_dir);
    end
    assign turn_beep = r_beep;
`else
    assign turn_beep = 1'b0;
`endif

    assign dir_out   = r_dir;
    assign dir_valid = r_dir_valid;
    assign run       = r_run;
    assign paused    = r_paused;
    assign restart   = r_restart;
    assign q_cnt     = r_cnt;
    assign drop      = r_drop;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl: linear stimulus with hand-computed expectations.
module tb_snake_dir_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] key_flag;
    logic [3:0] key_value;
    logic       ir_data_en;
    logic [7:0] ir_data;
    logic       step_tick;
    logic       game_over;
    logic [1:0] dir_out;
    logic       dir_valid, run, paused, restart, drop, turn_beep;
    logic [3:0] q_cnt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SNAKE_TURN_BEEP_EN
    localparam logic BEEP = 1'b1;
`else
    localparam logic BEEP = 1'b0;
`endif

    localparam logic [7:0] C_UP = 8'h18, C_LEFT = 8'h08, C_RIGHT = 8'h5A, C_PAUSE = 8'h1C;

    snake_dir_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .key_flag(key_flag), .key_value(key_value),
        .ir_data_en(ir_data_en), .ir_data(ir_data),
        .step_tick(step_tick), .game_over(game_over),
        .dir_out(dir_out), .dir_valid(dir_valid),
        .run(run), .paused(paused), .restart(restart),
        .q_cnt(q_cnt), .drop(drop), .turn_beep(turn_beep)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic [3:0] kf, input logic [3:0] kv, input logic ie,
                       input logic [7:0] id, input logic st, input logic go);
        key_flag = kf; key_value = kv; ir_data_en = ie; ir_data = id;
        step_tick = st; game_over = go;
        @(posedge sys_clk); #1;
        key_flag = 4'h0; key_value = 4'hF; ir_data_en = 1'b0; ir_data = 8'h00;
        step_tick = 1'b0; game_over = 1'b0;
    endtask

    task automatic key(input logic [3:0] kf); cyc(kf, ~kf, 1'b0, 8'h00, 1'b0, 1'b0); endtask
    task automatic ir(input logic [7:0] c);   cyc(4'h0, 4'hF, 1'b1, c, 1'b0, 1'b0);   endtask
    task automatic step();                    cyc(4'h0, 4'hF, 1'b0, 8'h00, 1'b1, 1'b0); endtask
    task automatic idle();                    cyc(4'h0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0); endtask

    initial begin
        sys_rst = 1'b1;
        key_flag = 4'h0; key_value = 4'hF; ir_data_en = 1'b0; ir_data = 8'h00;
        step_tick = 1'b0; game_over = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_dir", dir_out, 2'b11);
        chk("rst_run", run, 0);
        chk("rst_paused", paused, 0);
        chk("rst_qcnt", q_cnt, 0);
        chk("rst_pulses", {dir_valid, restart, drop, turn_beep}, 0);
        sys_rst = 1'b0;
        idle();

        // IDLE: right key starts the game with that heading
        key(4'b0001);
        chk("start_run", run, 1);
        chk("start_dir", dir_out, 2'b11);
        chk("start_qcnt", q_cnt, 0);

        key(4'b0010);                       // left is the reverse of right
        chk("rev_drop", drop, 1);
        chk("rev_qcnt", q_cnt, 0);
        key(4'b1000);                       // up
        chk("up_qcnt", q_cnt, 1);
        chk("up_nodrop", drop, 0);
        step();
        chk("step_dir", dir_out, 2'b00);
        chk("step_valid", dir_valid, 1);
        chk("step_beep", turn_beep, BEEP);
        chk("step_qcnt", q_cnt, 0);
        idle();
        chk("valid_clr", dir_valid, 0);

        key(4'b0001);                       // right, ref up -> accepted
        step();
        chk("right_dir", dir_out, 2'b11);
        step();                             // empty step
        chk("empty_valid", dir_valid, 1);
        chk("empty_dir", dir_out, 2'b11);
        chk("empty_beep", turn_beep, 0);

        // Fill the queue: up, left, down, right accepted, fifth up dropped on full
        key(4'b1000); key(4'b0010); key(4'b0100); key(4'b0001);
        chk("fill_qcnt", q_cnt, 4);
        chk("fill_nodrop", drop, 0);
        key(4'b1000);
        chk("full_drop", drop, 1);
        chk("full_qcnt", q_cnt, 4);
        step(); chk("pop1_dir", dir_out, 2'b00); chk("pop1_qcnt", q_cnt, 3);
        step(); chk("pop2_dir", dir_out, 2'b10); chk("pop2_beep", turn_beep, BEEP);
        step(); chk("pop3_dir", dir_out, 2'b01);
        step(); chk("pop4_dir", dir_out, 2'b11); chk("pop4_qcnt", q_cnt, 0);

        // Up key and IR left together: only up is taken
        cyc(4'b1000, 4'b0111, 1'b1, C_LEFT, 1'b0, 1'b0);
        chk("multi_drop", drop, 1);
        chk("multi_qcnt", q_cnt, 1);
        step();
        chk("multi_dir", dir_out, 2'b00);

        // Push and pop in the same cycle
        key(4'b0010);                       // left
        cyc(4'b0100, 4'b1011, 1'b0, 8'h00, 1'b1, 1'b0);  // down + step
        chk("pp_dir", dir_out, 2'b10);
        chk("pp_qcnt", q_cnt, 1);
        chk("pp_nodrop", drop, 0);
        key(4'b1000);                       // up is reverse of the queued down
        chk("tail_drop", drop, 1);
        chk("tail_qcnt", q_cnt, 1);
        step();
        chk("tail_dir", dir_out, 2'b01);

        ir(C_RIGHT);
        chk("ir_qcnt", q_cnt, 1);
        ir(8'hFF);
        chk("irbad_drop", drop, 0);
        chk("irbad_qcnt", q_cnt, 1);

        // Pause holds queue and ignores steps/keys
        ir(C_PAUSE);
        chk("pause_paused", paused, 1);
        chk("pause_run", run, 0);
        step();
        chk("pause_valid", dir_valid, 0);
        chk("pause_dir", dir_out, 2'b01);
        key(4'b1000);
        chk("pause_qcnt", q_cnt, 1);
        chk("pause_nodrop", drop, 0);
        ir(C_PAUSE);
        chk("resume_run", run, 1);
        chk("resume_paused", paused, 0);

        // game_over with two entries queued and a coincident step
        key(4'b1000);
        chk("go_pre_qcnt", q_cnt, 2);
        cyc(4'h0, 4'hF, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("go_run", run, 0);
        chk("go_qcnt", q_cnt, 0);
        chk("go_valid", dir_valid, 0);
        chk("go_dir", dir_out, 2'b01);
        ir(C_LEFT);
        chk("over_ign_restart", restart, 0);
        chk("over_ign_dir", dir_out, 2'b01);
        ir(C_PAUSE);
        chk("restart_pulse", restart, 1);
        chk("restart_dir", dir_out, 2'b11);
        chk("restart_state", {run, paused}, 0);
        idle();
        chk("restart_clr", restart, 0);

        // IDLE -> RUN via pause code; game_over beats a same-cycle pause
        ir(C_PAUSE);
        chk("idle_pause_run", run, 1);
        chk("idle_pause_dir", dir_out, 2'b11);
        cyc(4'h0, 4'hF, 1'b1, C_PAUSE, 1'b0, 1'b1);
        chk("go_wins", {run, paused}, 0);
        key(4'b0100);
        chk("key_restart", restart, 1);

        // Asynchronous reset mid-game
        key(4'b0010);
        chk("left_start_dir", dir_out, 2'b10);
        key(4'b1000);
        chk("pre_rst_qcnt", q_cnt, 1);
        sys_rst = 1'b1;
        #1;
        chk("arst_dir", dir_out, 2'b11);
        chk("arst_qcnt", q_cnt, 0);
        chk("arst_run", run, 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        idle();
        chk("post_rst_run", run, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
